// File: rtl/cmp_arbiter.sv
// cmp_arbiter: round-robin share of one equality comparator between two requesters.
// Optional CMP_ARB_STATS_EN adds a completed-compare counter and last-owner output.
module cmp_arbiter #(
   parameter int WIDTH = 16
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic             Req0,
   input  logic [WIDTH-1:0] A0,
   input  logic [WIDTH-1:0] B0,
   input  logic             Req1,
   input  logic [WIDTH-1:0] A1,
   input  logic [WIDTH-1:0] B1,
   output logic             Grant0,
   output logic             Grant1,
   output logic             Done0,
   output logic             Done1,
   output logic [WIDTH-1:0] Result,
   output logic [WIDTH-1:0] CmpA,
   output logic [WIDTH-1:0] CmpB,
   output logic             CmpControl,
`ifdef CMP_ARB_STATS_EN
   output logic [15:0]      CmpCount,
   output logic             LastOwner,
`endif
   input  logic [WIDTH-1:0] CmpR
);
   typedef enum logic [1:0] {IDLE, COMPARE, RESPOND} state_t;
   state_t r_state, w_next;
   logic r_prio, r_owner, w_win, w_any;
   logic [WIDTH-1:0] r_a, r_b, r_result;
   always_comb begin
      w_any = Req0 | Req1;
      w_win = (Req0 & Req1) ? r_prio : Req1;
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = w_any ? COMPARE : IDLE;
         COMPARE: w_next = RESPOND;
         default: w_next = IDLE;
      endcase
   end
   always_ff @(posedge CLK) begin
      if (Reset) begin
         r_state  <= IDLE;
         r_prio   <= 1'b0;
         r_owner  <= 1'b0;
         r_a      <= '0;
         r_b      <= '0;
         r_result <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == IDLE && w_any) begin
            r_owner <= w_win;
            r_a     <= w_win ? A1 : A0;
            r_b     <= w_win ? B1 : B0;
         end
         if (r_state == COMPARE) r_result <= {{(WIDTH-1){1'b0}}, CmpR[0]};
         if (r_state == RESPOND) r_prio <= ~r_owner;
      end
   end
`ifdef CMP_ARB_STATS_EN
   logic [15:0] r_count;
   logic        r_last;
   always_ff @(posedge CLK) begin
      if (Reset) begin
         r_count <= '0;
         r_last  <= 1'b0;
      end else if (r_state == RESPOND) begin
         r_count <= r_count + 16'd1;
         r_last  <= r_owner;
      end
   end
   assign CmpCount  = r_count;
   assign LastOwner = r_last;
`endif
   // Operand regs drive the comparator directly so they hold through RESPOND.
   assign CmpA       = r_a;
   assign CmpB       = r_b;
   assign CmpControl = (r_state == COMPARE);
   assign Grant0     = (r_state == COMPARE) & ~r_owner;
   assign Grant1     = (r_state == COMPARE) &  r_owner;
   assign Done0      = (r_state == RESPOND) & ~r_owner;
   assign Done1      = (r_state == RESPOND) &  r_owner;
   assign Result     = r_result;
endmodule
